pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl.sv | 93 +++++++++
 tb/tb_pipeline_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard/stall controller for a 6-stage pipeline with a multi-cycle MDU tracker.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   id_rs_en/id_rt_en, id_rs_addr/id_rt_addr      ID source operand reads
//   ex_mem_read_flag, ex_write_reg_addr           EX load and its destination
//   ex_mdu_start                 EX holds a multi-cycle op
//   mem_req, mem_ack             MEM access pending / completed
//   stall[5:0]                   prefix-shaped stall vector, [0]=PC .. [5]=WB
//   mdu_done                     multi-cycle result valid
//   mem_timeout                  sticky MEM-wait watchdog error
// Optional feature: define STALL_TIMEOUT_EN to build the MEM-wait watchdog.
module pipeline_ctrl #(
    parameter int MDU_LATENCY    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_rs_en,
    input  logic       id_rt_en,
    input  logic [4:0] id_rs_addr,
    input  logic [4:0] id_rt_addr,
    input  logic       ex_mem_read_flag,
    input  logic [4:0] ex_write_reg_addr,
    input  logic       ex_mdu_start,
    input  logic       mem_req,
    input  logic       mem_ack,
    output logic [5:0] stall,
    output logic       mdu_done,
    output logic       mem_timeout
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       load_use, ex_wait, mem_wait;
    assign load_use = ex_mem_read_flag && (ex_write_reg_addr != 5'd0) &&
                      ((id_rs_en && id_rs_addr == ex_write_reg_addr) ||
                       (id_rt_en && id_rt_addr == ex_write_reg_addr));
    assign ex_wait  = (state_q == BUSY);
    assign mem_wait = mem_req && !mem_ack;
    // Deepest requesting stage wins; WB is never stalled.
    always_comb begin
        stall    = rst      ? 6'b000000 :
                   mem_wait ? 6'b011111 :
                   ex_wait  ? 6'b001111 :
                   load_use ? 6'b000111 : 6'b000000;
        mdu_done = !rst && (state_q == DONE);
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == IDLE && ex_mdu_start) begin
            state_d = BUSY;
            cnt_d   = 4'(MDU_LATENCY - 1);
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? DONE : BUSY;
        end else if (state_q == DONE && !stall[4]) begin
            // Result is held until MEM no longer stalls EX.
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
`ifdef STALL_TIMEOUT_EN
    logic [7:0] wd_q, wd_d;
    logic       to_q, to_d;
    always_comb begin
        wd_d = mem_wait ? ((wd_q == 8'hFF) ? wd_q : wd_q + 8'd1) : 8'd0;
        to_d = to_q || (mem_wait && wd_q == 8'(TIMEOUT_CYCLES - 1));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= 8'd0;
            to_q <= 1'b0;
        end else begin
            wd_q <= wd_d;
            to_q <= to_d;
        end
    end
    assign mem_timeout = to_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign mem_timeout        = 1'b0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table-driven and sequence checks for pipeline_ctrl.
module tb_pipeline_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       id_rs_en, id_rt_en;
    logic [4:0] id_rs_addr, id_rt_addr;
    logic       ex_mem_read_flag;
    logic [4:0] ex_write_reg_addr;
    logic       ex_mdu_start;
    logic       mem_req, mem_ack;
    logic [5:0] stall;
    logic       mdu_done, mem_timeout;
    int         n_run = 0, n_fail = 0;
`ifdef STALL_TIMEOUT_EN
    localparam logic TO_EXP = 1'b1;
`else
    localparam logic TO_EXP = 1'b0;
`endif
    always #5 clk = ~clk;
    pipeline_ctrl #(.MDU_LATENCY(4), .TIMEOUT_CYCLES(3)) dut (
        .clk(clk), .rst(rst),
        .id_rs_en(id_rs_en), .id_rt_en(id_rt_en),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .ex_mem_read_flag(ex_mem_read_flag), .ex_write_reg_addr(ex_write_reg_addr),
        .ex_mdu_start(ex_mdu_start), .mem_req(mem_req), .mem_ack(mem_ack),
        .stall(stall), .mdu_done(mdu_done), .mem_timeout(mem_timeout)
    );
    typedef struct {
        logic       rs_en, rt_en;
        logic [4:0] rs, rt;
        logic       rd;
        logic [4:0] wr;
        logic       mreq, mack;
        logic [5:0] exp;
    } vec_t;
    vec_t v[10];
    task automatic chk(input string name, input logic [5:0] es, input logic ed);
        n_run++;
        if (stall !== es || mdu_done !== ed) begin
            n_fail++;
            $display("FAIL %s: stall=%b mdu_done=%b, required stall=%b mdu_done=%b",
                     name, stall, mdu_done, es, ed);
        end
    endtask
    task automatic chk_to(input string name, input logic et);
        n_run++;
        if (mem_timeout !== et) begin
            n_fail++;
            $display("FAIL %s: mem_timeout=%b, required %b", name, mem_timeout, et);
        end
    endtask
    task automatic idle_inputs();
        id_rs_en = 0; id_rt_en = 0; id_rs_addr = 0; id_rt_addr = 0;
        ex_mem_read_flag = 0; ex_write_reg_addr = 0;
        ex_mdu_start = 0; mem_req = 0; mem_ack = 0;
    endtask
    initial begin
        v[0] = '{1'b1, 1'b0, 5'd5,  5'd0,  1'b1, 5'd5,  1'b0, 1'b0, 6'b000111};
        v[1] = '{1'b1, 1'b1, 5'd0,  5'd0,  1'b1, 5'd0,  1'b0, 1'b0, 6'b000000};
        v[2] = '{1'b0, 1'b0, 5'd7,  5'd7,  1'b1, 5'd7,  1'b0, 1'b0, 6'b000000};
        v[3] = '{1'b0, 1'b1, 5'd2,  5'd9,  1'b1, 5'd9,  1'b0, 1'b0, 6'b000111};
        v[4] = '{1'b1, 1'b1, 5'd9,  5'd9,  1'b0, 5'd9,  1'b0, 1'b0, 6'b000000};
        v[5] = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 6'b011111};
        v[6] = '{1'b0, 1'b0, 5'd0,  5'd0,  1'b0, 5'd0,  1'b1, 1'b1, 6'b000000};
        v[7] = '{1'b1, 1'b0, 5'd12, 5'd0,  1'b1, 5'd12, 1'b1, 1'b0, 6'b011111};
        v[8] = '{1'b1, 1'b1, 5'd3,  5'd4,  1'b1, 5'd5,  1'b0, 1'b0, 6'b000000};
        v[9] = '{1'b1, 1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 1'b0, 1'b0, 6'b000111};
        idle_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        // Reset dominates even with every request active.
        id_rs_en = 1; id_rs_addr = 5'd5; ex_mem_read_flag = 1; ex_write_reg_addr = 5'd5;
        mem_req = 1; ex_mdu_start = 1;
        #1 chk("reset_outputs", 6'b000000, 1'b0);
        chk_to("reset_timeout", 1'b0);
        @(negedge clk);
        idle_inputs();
        rst = 0;
        #1 chk("after_reset_idle", 6'b000000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_rs_en = v[i].rs_en; id_rt_en = v[i].rt_en;
            id_rs_addr = v[i].rs; id_rt_addr = v[i].rt;
            ex_mem_read_flag = v[i].rd; ex_write_reg_addr = v[i].wr;
            mem_req = v[i].mreq; mem_ack = v[i].mack;
            #1 chk($sformatf("vec%0d", i), v[i].exp, 1'b0);
        end
        // Load-use: one bubble, then the load has moved on.
        @(negedge clk);
        idle_inputs();
        id_rs_en = 1; id_rs_addr = 5'd5; ex_mem_read_flag = 1; ex_write_reg_addr = 5'd5;
        #1 chk("loaduse_stall", 6'b000111, 1'b0);
        @(negedge clk);
        ex_mem_read_flag = 0; ex_write_reg_addr = 5'd0;
        #1 chk("loaduse_bubble_done", 6'b000000, 1'b0);
        // Basic MDU op, latency 4.
        @(negedge clk);
        idle_inputs();
        ex_mdu_start = 1;
        #1 chk("mdu_start_idle", 6'b000000, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk($sformatf("mdu_busy%0d", i), 6'b001111, 1'b0);
        end
        @(negedge clk);
        chk("mdu_done", 6'b000000, 1'b1);
        ex_mdu_start = 0;
        @(negedge clk);
        chk("mdu_back_idle", 6'b000000, 1'b0);
        // MDU held in DONE by a MEM wait; start stays high but must not restart.
        ex_mdu_start = 1;
        repeat (4) @(negedge clk);
        mem_req = 1; mem_ack = 0;
        #1 chk("done_memwait1", 6'b011111, 1'b1);
        @(negedge clk);
        chk("done_memwait2", 6'b011111, 1'b1);
        @(negedge clk);
        mem_req = 0;
        #1 chk("done_released", 6'b000000, 1'b1);
        ex_mdu_start = 0;
        @(negedge clk);
        chk("done_no_restart", 6'b000000, 1'b0);
        // Reset mid-BUSY aborts the op.
        ex_mdu_start = 1;
        repeat (2) @(negedge clk);
        chk("busy_before_rst", 6'b001111, 1'b0);
        rst = 1; ex_mdu_start = 0;
        #1 chk("busy_in_rst", 6'b000000, 1'b0);
        @(negedge clk);
        rst = 0;
        #1 chk("busy_after_rst", 6'b000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("abort_no_done%0d", i), 6'b000000, 1'b0);
        end
        // MEM-wait watchdog with TIMEOUT_CYCLES=3.
        mem_req = 1; mem_ack = 0;
        repeat (2) @(negedge clk);
        chk_to("timeout_before_limit", 1'b0);
        @(negedge clk);
        chk_to("timeout_at_limit", TO_EXP);
        chk("timeout_still_stalls", 6'b011111, 1'b0);
        mem_req = 0;
        @(negedge clk);
        chk_to("timeout_sticky", TO_EXP);
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1 chk_to("timeout_cleared", 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
